// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 prescaler: register addresses, ratio codes
// and the code-to-length helpers used by the decode and the divider.
package jt12_pkg;

    localparam logic [7:0] REG_PRE6 = 8'h2D;
    localparam logic [7:0] REG_PRE3 = 8'h2E;
    localparam logic [7:0] REG_PRE2 = 8'h2F;

    typedef enum logic [1:0] {
        DIV6 = 2'd0,
        DIV3 = 2'd1,
        DIV2 = 2'd2
    } div_t;

    function automatic logic [2:0] div_len(input div_t d);
        case (d)
            DIV3:    return 3'd3;
            DIV2:    return 3'd2;
            default: return 3'd6;
        endcase
    endfunction

    // Maps an integer ratio parameter onto its code; unknown values fall back to /6.
    function automatic div_t div_code(input int n);
        case (n)
            3:       return DIV3;
            2:       return DIV2;
            default: return DIV6;
        endcase
    endfunction

endpackage

// File: rtl/jt12_cen_gen.sv
// Master-clock enable generator: modulo-N counter, wrap-time ratio load, cen
// and the cen-synchronised internal reset. JT12_FIXED_DIV_EN pins the ratio.
module jt12_cen_gen
    import jt12_pkg::*;
#(
    parameter int DEF_DIV = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  div_t req_sel,
    output logic cen,
    output div_t div_sel,
    output logic rst_int
);

    localparam div_t DIV_RST = div_code(DEF_DIV);

    logic [2:0] cnt_q, cnt_d;
    logic       cen_q, cen_d;
    div_t       div_sel_q, div_sel_d;
    logic       rst_aux_q, rst_aux_d;
    logic       rst_int_q, rst_int_d;
    logic       wrap;

`ifndef JT12_FIXED_DIV_EN
    div_t pend_sel_q, pend_sel_d;
    logic pend_valid_q, pend_valid_d;
`else
    logic unused_req;
    assign unused_req = req_valid ^ (^req_sel);
`endif

    always_comb begin
        // >= keeps the counter self-correcting should it ever exceed N-1
        wrap      = (cnt_q >= (div_len(div_sel_q) - 3'd1));
        cnt_d     = wrap ? 3'd0 : cnt_q + 3'd1;
        cen_d     = wrap;
        rst_aux_d = cen_q ? 1'b0 : rst_aux_q;
        rst_int_d = cen_q ? rst_aux_q : rst_int_q;
`ifdef JT12_FIXED_DIV_EN
        div_sel_d = DIV_RST;
`else
        div_sel_d    = div_sel_q;
        pend_sel_d   = pend_sel_q;
        pend_valid_d = pend_valid_q;
        if (wrap && pend_valid_q) begin
            div_sel_d    = pend_sel_q;
            pend_valid_d = 1'b0;
        end
        // A request landing on the wrap edge survives for the following wrap
        if (req_valid) begin
            pend_sel_d   = req_sel;
            pend_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 3'd0;
            cen_q     <= 1'b0;
            div_sel_q <= DIV_RST;
            rst_aux_q <= 1'b1;
            rst_int_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            cen_q     <= cen_d;
            div_sel_q <= div_sel_d;
            rst_aux_q <= rst_aux_d;
            rst_int_q <= rst_int_d;
        end
    end

`ifndef JT12_FIXED_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_sel_q   <= DIV_RST;
            pend_valid_q <= 1'b0;
        end else begin
            pend_sel_q   <= pend_sel_d;
            pend_valid_q <= pend_valid_d;
        end
    end
`endif

    assign cen     = cen_q;
    assign div_sel = div_sel_q;
    assign rst_int = rst_int_q;

endmodule

// File: rtl/jt12_prescaler.sv
// CPU-side prescaler control: port A address latch, 0x2D/0x2E/0x2F decode and
// set_n* pulses; ratio switching lives in jt12_cen_gen (see JT12_FIXED_DIV_EN).
module jt12_prescaler
    import jt12_pkg::*;
#(
    parameter int DEF_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_wr,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       set_n6,
    output logic       set_n3,
    output logic       set_n2,
    output logic       cen,
    output logic [1:0] div_sel,
    output logic       rst_int
);

    logic [7:0] addr_a_q, addr_a_d;
    logic       set_n6_q, set_n6_d;
    logic       set_n3_q, set_n3_d;
    logic       set_n2_q, set_n2_d;
    logic       data_wr_a;
    logic       req_valid;
    div_t       req_sel;
    div_t       div_sel_w;

    always_comb begin
        addr_a_d = addr_a_q;
        if (cpu_wr) begin
            case (cpu_addr)
                2'b00:   addr_a_d = cpu_din;
                // Port B addressing hides port A until it is re-addressed
                2'b10:   addr_a_d = 8'h00;
                default: addr_a_d = addr_a_q;
            endcase
        end

        data_wr_a = cpu_wr && (cpu_addr == 2'b01);
        set_n6_d  = data_wr_a && (addr_a_q == REG_PRE6);
        set_n3_d  = data_wr_a && (addr_a_q == REG_PRE3);
        set_n2_d  = data_wr_a && (addr_a_q == REG_PRE2);

        req_valid = set_n6_d | set_n3_d | set_n2_d;
        if (set_n3_d)      req_sel = DIV3;
        else if (set_n2_d) req_sel = DIV2;
        else               req_sel = DIV6;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_a_q <= 8'h00;
            set_n6_q <= 1'b0;
            set_n3_q <= 1'b0;
            set_n2_q <= 1'b0;
        end else begin
            addr_a_q <= addr_a_d;
            set_n6_q <= set_n6_d;
            set_n3_q <= set_n3_d;
            set_n2_q <= set_n2_d;
        end
    end

    jt12_cen_gen #(
        .DEF_DIV (DEF_DIV)
    ) u_cen_gen (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .cen       (cen),
        .div_sel   (div_sel_w),
        .rst_int   (rst_int)
    );

    assign set_n6  = set_n6_q;
    assign set_n3  = set_n3_q;
    assign set_n2  = set_n2_q;
    assign div_sel = div_sel_w;

endmodule

// File: tb/tb_jt12_prescaler.sv
// Directed bench for jt12_prescaler: expected set_* pulses and cen periods are
// queued as stimulus is applied and compared as the DUT produces them.
module tb_jt12_prescaler;

`ifdef JT12_FIXED_DIV_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_wr;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       set_n6, set_n3, set_n2, cen, rst_int;
    logic [1:0] div_sel;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cen = 0;
    bit cen_seen;
    logic [2:0] set_q[$];
    int per_q[$];

    jt12_prescaler #(.DEF_DIV(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .set_n6   (set_n6),
        .set_n3   (set_n3),
        .set_n2   (set_n2),
        .cen      (cen),
        .div_sel  (div_sel),
        .rst_int  (rst_int)
    );

    always #5 clk = ~clk;

    function automatic int per(input int n);
        return FIXED ? 6 : n;
    endfunction

    function automatic int dcode(input int c);
        return FIXED ? 0 : c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [2:0] e;
        @(posedge clk);
        #1;
        cyc++;
        e = (set_q.size() > 0) ? set_q.pop_front() : 3'b000;
        check("set_pulse", {29'd0, set_n6, set_n3, set_n2}, {29'd0, e});
        if (cen === 1'b1) begin
            if (per_q.size() > 0) check("cen_period", cyc - last_cen, per_q.pop_front());
            last_cen = cyc;
            cen_seen = 1'b1;
        end
    endtask

    task automatic wait_cen();
        cen_seen = 1'b0;
        for (int i = 0; i < 20 && !cen_seen; i++) tick();
        check("cen_timeout", {31'd0, cen_seen}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && per_q.size() > 0; i++) wait_cen();
    endtask

    // exp is {set_n6,set_n3,set_n2} expected in the cycle after this write
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [2:0] exp);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        set_q.push_back(exp);
        tick();
        cpu_wr   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cpu_wr = 1'b0;
        cpu_addr = 2'b00;
        cpu_din = 8'h00;

        // Reset state and the default /6 cadence
        tick();
        check("rst_cen", {31'd0, cen}, 32'd0);
        check("rst_div_sel", {30'd0, div_sel}, 32'd0);
        check("rst_rst_int", {31'd0, rst_int}, 32'd1);
        tick();
        rst = 1'b0;
        last_cen = cyc;
        per_q.push_back(6);
        per_q.push_back(6);
        wait_cen();
        check("rst_int_cen1", {31'd0, rst_int}, 32'd1);
        check("div_sel_def", {30'd0, div_sel}, 32'd0);
        wait_cen();
        check("rst_int_cen2", {31'd0, rst_int}, 32'd1);
        tick();
        check("rst_int_release", {31'd0, rst_int}, 32'd0);

        // /6 -> /3: whole old period, then whole new ones
        per_q.push_back(6);
        per_q.push_back(per(3));
        per_q.push_back(per(3));
        per_q.push_back(per(3));
        wr(2'b00, 8'h2E, 3'b000);
        wr(2'b01, 8'hA5, 3'b010);
        drain();
        check("div_sel_n3", {30'd0, div_sel}, dcode(1));

        // Port B never decodes and its address write blanks port A
        wr(2'b00, 8'h2D, 3'b000);
        wr(2'b11, 8'h55, 3'b000);
        wr(2'b10, 8'h2D, 3'b000);
        wr(2'b01, 8'h00, 3'b000);
        wr(2'b00, 8'h28, 3'b000);
        wr(2'b01, 8'h00, 3'b000);
        tick();
        check("div_sel_after_portb", {30'd0, div_sel}, dcode(1));

        // Reset mid-period with /2 pending
        wait_cen();
        wr(2'b00, 8'h2F, 3'b000);
        wr(2'b01, 8'h00, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_set", {29'd0, set_n6, set_n3, set_n2}, 32'd0);
        check("midrst_cen", {31'd0, cen}, 32'd0);
        check("midrst_div_sel", {30'd0, div_sel}, 32'd0);
        check("midrst_rst_int", {31'd0, rst_int}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        last_cen = cyc;
        per_q.push_back(6);
        drain();
        check("post_rst_div_sel", {30'd0, div_sel}, 32'd0);

        // Two prescaler writes in one period: last one wins
        per_q.push_back(6);
        per_q.push_back(per(2));
        per_q.push_back(per(2));
        per_q.push_back(per(2));
        wr(2'b00, 8'h2E, 3'b000);
        wr(2'b01, 8'h00, 3'b010);
        wr(2'b00, 8'h2F, 3'b000);
        wr(2'b01, 8'h00, 3'b001);
        drain();
        check("div_sel_n2", {30'd0, div_sel}, dcode(2));

        // /2 -> /6 with the data write landing on the wrap edge
        per_q.push_back(per(2));
        per_q.push_back(per(2));
        per_q.push_back(6);
        per_q.push_back(6);
        wr(2'b00, 8'h2D, 3'b000);
        wr(2'b01, 8'h00, 3'b100);
        drain();
        check("div_sel_n6", {30'd0, div_sel}, 32'd0);

        check("per_q_drained", per_q.size(), 32'd0);
        check("set_q_drained", set_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
